fetch_pc_unit: RTL and testbench

// - Fetch-stage PC register and next-address generator for the 3-stage RISC-V core.
// - Consumes PCSignal from the PC-select control, drives the synchronous icache read address,
//   and registers fetched instructions into prev_inst, which feeds back to PC-select and decode.
// - Inserts NOP bubbles on redirect or replay and counts retired-into-decode instructions.

---
 rtl/fetch_pc_unit_pkg.sv | 32 +++
 rtl/fetch_pc_unit_if.sv | 29 ++
 rtl/fetch_pc_unit_pc_next_mux.sv | 56 +++++
 rtl/fetch_pc_unit.sv | 137 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared definitions for the fetch-stage PC unit: FSM state encoding, PC-select
// codes, the bubble instruction, the boot address and a word-alignment helper.
// Imported by the fetch interface users, the next-address mux and the top.
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

    // PC-select codes driven by the PC-select control block.
    // 2'b11 is decoded exactly like PCSEL_SEQ.
    localparam logic [1:0] PCSEL_REPLAY = 2'b00;
    localparam logic [1:0] PCSEL_ALU    = 2'b01;
    localparam logic [1:0] PCSEL_SEQ    = 2'b10;

    // addi x0,x0,0 -- the bubble inserted on redirect or replay.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // BIOS base: first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Instruction fetches are always word aligned; bit 1 of a redirect target
    // is dropped here and reported separately through the misalign flag.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Synchronous instruction-cache read port (1-cycle read latency).
//   addr : fetch address presented this cycle
//   re   : read enable
//   dout : instruction at the address presented in the previous cycle
// Modports:
//   master : fetch side (drives addr/re, receives dout)
//   slave  : icache side
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if;

    logic [31:0] addr;
    logic        re;
    logic [31:0] dout;

    modport master (
        output addr,
        output re,
        input  dout
    );

    modport slave (
        input  addr,
        input  re,
        output dout
    );

endinterface

// File: rtl/fetch_pc_unit_pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-fetch-address and squash generator.
//   state      in   FSM state of the fetch unit
//   stall      in   global pipeline stall (wins over pc_sel while running)
//   pc_sel     in   PC-select code
//   fetch_pc   in   PC of the instruction currently on the icache output
//   alu_target in   redirect target from the ALU
//   next_addr  out  address presented to the icache this cycle
//   kill       out  the instruction on the icache output is squashed
// -----------------------------------------------------------------------------
module pc_next_mux
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  fetch_state_e state,
    input  logic         stall,
    input  logic [1:0]   pc_sel,
    input  logic [31:0]  fetch_pc,
    input  logic [31:0]  alu_target,
    output logic [31:0]  next_addr,
    output logic         kill
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can
        // leave a value unassigned and infer a latch.
        next_addr = fetch_pc;
        kill      = 1'b0;

        if (state == ST_BOOT) begin
            // Nothing valid on the icache output yet.
            next_addr = RESET_PC;
            kill      = 1'b1;
        end else if (stall) begin
            // Re-read the current address so dout stays valid across the stall.
            next_addr = fetch_pc;
        end else begin
            case (pc_sel)
                PCSEL_ALU: begin
                    next_addr = align_word(alu_target);
                    kill      = 1'b1;
                end
                PCSEL_REPLAY: begin
                    next_addr = fetch_pc;
                    kill      = 1'b1;
                end
                default: begin
                    next_addr = fetch_pc + 32'd4;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage PC register and next-address generator for the 3-stage core.
// Presents the next fetch address to a synchronous icache, registers fetched
// instructions into prev_inst, inserts NOP bubbles on redirect/replay and
// counts instructions accepted into decode.
//   clk, rst_n  in   core clock, asynchronous active-low reset
//   stall       in   global pipeline stall, priority over PCSignal
//   PCSignal    in   00 replay+bubble, 01 ALU target, 10/11 sequential
//   alu_target  in   branch/jalr target, valid with PCSignal=01
//   icache      if   icache read port (master side)
//   fetch_pc    out  PC of the instruction currently on icache.dout
//   prev_inst   out  instruction held in decode/execute
//   prev_pc     out  PC of prev_inst
//   kill        out  icache.dout is squashed this cycle
//   inst_count  out  number of non-bubble instructions accepted
//   misalign    out  sticky: a redirect target had bit 1 set
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic [1:0]             PCSignal,
    input  logic [31:0]            alu_target,
    fetch_pc_unit_if.master        icache,
    output logic [31:0]            fetch_pc,
    output logic [31:0]            prev_inst,
    output logic [31:0]            prev_pc,
    output logic                   kill,
    output logic [31:0]            inst_count,
    output logic                   misalign
);

    fetch_state_e state;
    fetch_state_e state_next;
    logic [31:0]  next_addr;
    logic         bubble;
    logic         accept;
    logic         set_misalign;

    pc_next_mux #(
        .RESET_PC (RESET_PC)
    ) u_pc_next_mux (
        .state      (state),
        .stall      (stall),
        .pc_sel     (PCSignal),
        .fetch_pc   (fetch_pc),
        .alu_target (alu_target),
        .next_addr  (next_addr),
        .kill       (kill)
    );

    assign icache.addr = next_addr;
    // The icache is read every cycle the core is out of reset.
    assign icache.re   = rst_n;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_next   = state;
        bubble       = 1'b0;
        accept       = 1'b0;
        set_misalign = 1'b0;

        case (state)
            ST_BOOT: begin
                bubble = 1'b1;
                if (!stall) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    case (PCSignal)
                        PCSEL_ALU: begin
                            bubble       = 1'b1;
                            set_misalign = alu_target[1];
                        end
                        PCSEL_REPLAY: begin
                            bubble = 1'b1;
                        end
                        default: begin
                            accept = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            prev_inst  <= NOP_INST;
            prev_pc    <= RESET_PC;
            inst_count <= '0;
            misalign   <= 1'b0;
        end else begin
            // In every case the address just sent to the icache is exactly the
            // PC whose instruction will be on dout next cycle (boot, hold on
            // stall/replay, redirect, +4), so fetch_pc simply follows it.
            fetch_pc <= next_addr;

            if (bubble) begin
                prev_inst <= NOP_INST;
            end else if (accept) begin
                prev_inst  <= icache.dout;
                prev_pc    <= fetch_pc;
                inst_count <= inst_count + 32'd1;
            end

            if (set_misalign) begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit: a synchronous icache model, a
// behavioural reference of the fetch rules compared every cycle, and directed
// vectors with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_signal;
    logic [31:0] alu_target;
    logic [31:0] fetch_pc;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        kill;
    logic [31:0] inst_count;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit_if ifc ();

    fetch_pc_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .PCSignal   (pc_signal),
        .alu_target (alu_target),
        .icache     (ifc),
        .fetch_pc   (fetch_pc),
        .prev_inst  (prev_inst),
        .prev_pc    (prev_pc),
        .kill       (kill),
        .inst_count (inst_count),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: distinct per word, never equal to the NOP.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[31:2] ^ 30'h1234_5678, 2'b01};
    endfunction

    // Synchronous icache with one cycle of read latency.
    always @(posedge clk) begin
        if (ifc.re) begin
            ifc.dout <= mem(ifc.addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ppc;
    logic [31:0] m_count;
    logic        m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot  <= 1'b1;
            m_pc    <= RST_PC;
            m_inst  <= NOP;
            m_ppc   <= RST_PC;
            m_count <= 32'd0;
            m_mis   <= 1'b0;
        end else if (m_boot) begin
            m_pc   <= RST_PC;
            m_inst <= NOP;
            m_boot <= stall;
        end else if (!stall) begin
            if (pc_signal == 2'b01) begin
                m_pc   <= alu_target & 32'hFFFF_FFFC;
                m_inst <= NOP;
                if (alu_target[1]) m_mis <= 1'b1;
            end else if (pc_signal == 2'b00) begin
                m_inst <= NOP;
            end else begin
                m_pc    <= m_pc + 32'd4;
                m_inst  <= mem(m_pc);
                m_ppc   <= m_pc;
                m_count <= m_count + 32'd1;
            end
        end
    end

    // Compare process: inputs change at negedge+1, outputs checked at negedge+2.
    always @(negedge clk) begin
        logic [31:0] e_addr;
        logic        e_kill;
        #2;
        e_kill = 1'b0;
        if (!rst_n || m_boot) begin
            e_addr = RST_PC;
            e_kill = 1'b1;
        end else if (stall) begin
            e_addr = m_pc;
        end else if (pc_signal == 2'b01) begin
            e_addr = alu_target & 32'hFFFF_FFFC;
            e_kill = 1'b1;
        end else if (pc_signal == 2'b00) begin
            e_addr = m_pc;
            e_kill = 1'b1;
        end else begin
            e_addr = m_pc + 32'd4;
        end
        check("icache_addr", ifc.addr, e_addr);
        check("kill", {31'd0, kill}, {31'd0, e_kill});
        check("icache_re", {31'd0, ifc.re}, {31'd0, rst_n});
        check("fetch_pc", fetch_pc, m_pc);
        check("prev_inst", prev_inst, m_inst);
        check("prev_pc", prev_pc, m_ppc);
        check("inst_count", inst_count, m_count);
        check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic st, input logic [1:0] sel, input logic [31:0] tgt);
        @(negedge clk);
        #1;
        stall      = st;
        pc_signal  = sel;
        alu_target = tgt;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        pc_signal  = 2'b10;
        alu_target = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("boot_addr", ifc.addr, 32'h4000_0000);
        check("boot_kill", {31'd0, kill}, 32'd1);

        // Sequential run from the boot address.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'b10, 32'd0);
            if (i == 0) begin
                check("first_run_addr", ifc.addr, 32'h4000_0004);
                check("first_run_prev_inst", prev_inst, 32'h0000_0013);
            end else begin
                check("seq_prev_pc", prev_pc, 32'h4000_0000 + 32'(4 * (i - 1)));
            end
        end

        // Replay twice at 0x4000_0010.
        cyc(1'b0, 2'b00, 32'd0);
        check("seq4_prev_pc", prev_pc, 32'h4000_000C);
        check("seq4_count", inst_count, 32'd4);
        check("replay1_addr", ifc.addr, 32'h4000_0010);
        cyc(1'b0, 2'b00, 32'd0);
        check("replay2_addr", ifc.addr, 32'h4000_0010);
        check("replay_prev_inst", prev_inst, 32'h0000_0013);
        check("replay_count", inst_count, 32'd4);
        cyc(1'b0, 2'b10, 32'd0);

        // Aligned-ish redirect (bit1 clear), then misaligned redirect.
        cyc(1'b0, 2'b01, 32'h1000_0011);
        check("alu_addr", ifc.addr, 32'h1000_0010);
        check("alu_kill", {31'd0, kill}, 32'd1);
        cyc(1'b0, 2'b10, 32'd0);
        check("alu_prev_inst", prev_inst, 32'h0000_0013);
        check("alu_misalign", {31'd0, misalign}, 32'd0);
        cyc(1'b0, 2'b01, 32'h1000_0002);
        cyc(1'b0, 2'b10, 32'd0);
        check("misalign_set", {31'd0, misalign}, 32'd1);

        // PC wrap and PCSignal=11.
        cyc(1'b0, 2'b01, 32'hFFFF_FFFC);
        cyc(1'b0, 2'b10, 32'd0);
        check("wrap_addr", ifc.addr, 32'h0000_0000);
        cyc(1'b0, 2'b11, 32'd0);
        check("sel11_addr", ifc.addr, 32'h0000_0004);
        check("misalign_sticky", {31'd0, misalign}, 32'd1);

        // Stall with a pending redirect: nothing moves.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b01, 32'h2000_0000);
            check("stall_addr", ifc.addr, 32'h0000_0004);
            check("stall_kill", {31'd0, kill}, 32'd0);
        end

        // Reset pulse mid-stall.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_addr", ifc.addr, RST_PC);
        check("rst_re", {31'd0, ifc.re}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_count", inst_count, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        // Stall during BOOT keeps BOOT.
        cyc(1'b1, 2'b10, 32'd0);
        check("boot_stall_addr", ifc.addr, RST_PC);
        check("boot_stall_kill", {31'd0, kill}, 32'd1);
        cyc(1'b0, 2'b10, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b10, 32'd0);
        end
        check("restart_count", inst_count, 32'd2);

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
